// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage branch hazard controller: forward selects,
// controller states and the implicit-R15 register number.
package branch_ctrl_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] R15_ADDR = 4'hF;

  typedef enum logic [2:0] {
    HS_NONE   = 3'b000,
    HS_EX_LO  = 3'b001,
    HS_EX_HI  = 3'b010,
    HS_MEM_LO = 3'b011,
    HS_MEM_HI = 3'b100
  } hs_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Width of the flush down-counter, which holds at most n-1.
  function automatic int flush_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline <-> branch hazard controller signal bundle. The pipeline side is the
// master (presents ID/EX/MEM state), the controller is the slave.
interface branch_hazard_ctrl_if;
  import branch_ctrl_pkg::*;

  logic             id_branch;
  logic             id_jump;
  logic [REG_W-1:0] id_op1_reg;
  logic [REG_W-1:0] ex_dest_reg;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_wide;
  logic [REG_W-1:0] mem_dest_reg;
  logic             mem_reg_write;
  logic             mem_wide;
  logic             branch_taken;

  logic             hazard;
  logic [2:0]       hazard_select;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pc_src_branch;

  modport master (
    output id_branch, id_jump, id_op1_reg,
    output ex_dest_reg, ex_reg_write, ex_mem_read, ex_wide,
    output mem_dest_reg, mem_reg_write, mem_wide,
    output branch_taken,
    input  hazard, hazard_select, pc_write_en, ifid_write_en,
    input  ifid_flush, idex_flush, pc_src_branch
  );

  modport slave (
    input  id_branch, id_jump, id_op1_reg,
    input  ex_dest_reg, ex_reg_write, ex_mem_read, ex_wide,
    input  mem_dest_reg, mem_reg_write, mem_wide,
    input  branch_taken,
    output hazard, hazard_select, pc_write_en, ifid_write_en,
    output ifid_flush, idex_flush, pc_src_branch
  );

endinterface

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Enable-increment counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: picks the comparator's Op1 forward path, stalls on
// unforwardable operands, redirects/flushes on taken branches and jumps.
module branch_hazard_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_hazard_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]     taken_count,
  output logic [CNT_W-1:0]     stall_count
);

  localparam int FC_W = flush_cnt_w(FLUSH_CYCLES);

  state_e          state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  hs_e             sel;
  logic            in_run;
  logic            cond_br;
  logic            load_use;
  logic            r15_pend;
  logic            stall;
  logic            resolve;

  assign in_run  = (state_q == ST_RUN);
  assign cond_br = in_run && bus.id_branch && !bus.id_jump;

  // Op1 forward select: EX before MEM, low half before high half.
  always_comb begin
    sel = HS_NONE;
    if (cond_br) begin
      if (bus.ex_reg_write && !bus.ex_mem_read && (bus.ex_dest_reg == bus.id_op1_reg)) begin
        sel = HS_EX_LO;
      end else if (bus.ex_wide && (bus.id_op1_reg == R15_ADDR)) begin
        sel = HS_EX_HI;
      end else if (bus.mem_reg_write && (bus.mem_dest_reg == bus.id_op1_reg)) begin
        sel = HS_MEM_LO;
      end else if (bus.mem_wide && (bus.id_op1_reg == R15_ADDR)) begin
        sel = HS_MEM_HI;
      end
    end
  end

  assign bus.hazard_select = sel;
  assign bus.hazard        = (sel != HS_NONE);

  // The comparator reads R15 implicitly with no bypass, so any in-flight R15 write blocks it.
  assign load_use = bus.ex_mem_read && bus.ex_reg_write && (bus.ex_dest_reg == bus.id_op1_reg);
  assign r15_pend = bus.ex_wide || bus.mem_wide
                 || (bus.ex_reg_write  && (bus.ex_dest_reg  == R15_ADDR))
                 || (bus.mem_reg_write && (bus.mem_dest_reg == R15_ADDR));
  assign stall    = cond_br && (load_use || r15_pend);
  assign resolve  = in_run && (bus.id_branch || bus.id_jump) && !stall && bus.branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    fcnt_d            = fcnt_q;
    bus.pc_write_en   = 1'b0;
    bus.ifid_write_en = 1'b0;
    bus.ifid_flush    = 1'b0;
    bus.idex_flush    = 1'b0;
    bus.pc_src_branch = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        bus.pc_write_en   = 1'b1;
        bus.ifid_write_en = 1'b1;
        if (stall) begin
          bus.pc_write_en   = 1'b0;
          bus.ifid_write_en = 1'b0;
          bus.idex_flush    = 1'b1;
        end else if (resolve) begin
          bus.pc_src_branch = 1'b1;
          bus.ifid_flush    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLUSH: begin
        bus.ifid_flush = 1'b1;
        if (fcnt_q <= FC_W'(1)) begin
          state_d = ST_RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d  = fcnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (resolve),
    .count (taken_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (stall),
    .count (stall_count)
  );

endmodule
